// File: rtl/dbg_frame_bridge.sv
// Debug frame bridge. It turns CMD/ADDR/DATA byte frames from the host link into one debug command and returns 4 read bytes.
// Defining DBG_FRAME_CSUM_EN adds a trailing XOR checksum byte; a bad checksum is answered with the single byte 0xEE.
module dbg_frame_bridge #(
  parameter int unsigned TIMEOUT_CYCLES = 1000000
) (
  input  logic        clk,
  input  logic        rst_i,
  input  logic [7:0]  rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [7:0]  tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i,
  output logic [7:0]  dbg_cmd_o,
  output logic [31:0] dbg_addr_o,
  output logic [31:0] dbg_data_o,
  input  logic [31:0] dbg_data_i,
  input  logic        dbg_ready_i,
  output logic        busy_o
);

`ifdef DBG_FRAME_CSUM_EN
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_CSUM, S_ISSUE, S_WAIT, S_RESP, S_ERR
  } state_t;
`else
  typedef enum logic [2:0] {
    S_IDLE, S_ADDR, S_DATA, S_ISSUE, S_WAIT, S_RESP
  } state_t;
`endif

  // The timeout fires on the edge where the idle counter would reach TIMEOUT_CYCLES.
  localparam logic [31:0] TMO_LAST = (TIMEOUT_CYCLES == 0) ? 32'd0 : 32'(TIMEOUT_CYCLES - 1);

  state_t      r_state;
  state_t      w_stateNext;
  logic [1:0]  r_idx;
  logic [31:0] r_tmo;
  logic [7:0]  r_cmd;
  logic [31:0] r_addr;
  logic [31:0] r_data;
  logic [31:0] r_resp;
`ifdef DBG_FRAME_CSUM_EN
  logic [7:0]  r_csum;
`endif

  logic w_rxOpen;
  logic w_rxFire;
  logic w_txFire;
  logic w_tmoHit;
  logic w_frameState;

`ifdef DBG_FRAME_CSUM_EN
  assign w_frameState = (r_state == S_ADDR) || (r_state == S_DATA) || (r_state == S_CSUM);
`else
  assign w_frameState = (r_state == S_ADDR) || (r_state == S_DATA);
`endif
  assign w_rxOpen   = !rst_i && ((r_state == S_IDLE) || w_frameState);
  assign w_rxFire   = w_rxOpen && rx_valid_i;
  assign w_txFire   = tx_valid_o && tx_ready_i;
  assign w_tmoHit   = (TIMEOUT_CYCLES != 0) && (r_tmo == TMO_LAST);

  assign rx_ready_o = w_rxOpen;
  assign dbg_addr_o = r_addr;
  assign dbg_data_o = r_data;
  assign busy_o     = (r_state != S_IDLE);

  always_comb begin
    w_stateNext = r_state;
    tx_valid_o  = 1'b0;
    tx_data_o   = 8'h00;
    dbg_cmd_o   = 8'h00;
    unique case (r_state)
      S_IDLE: begin
        if (w_rxFire && (rx_data_i != 8'h00)) w_stateNext = S_ADDR;
      end
      S_ADDR: begin
        if (w_rxFire) begin
          if (r_idx == 2'd3) w_stateNext = S_DATA;
        end else if (w_tmoHit) begin
          w_stateNext = S_IDLE;
        end
      end
      S_DATA: begin
        if (w_rxFire) begin
`ifdef DBG_FRAME_CSUM_EN
          if (r_idx == 2'd3) w_stateNext = S_CSUM;
`else
          if (r_idx == 2'd3) w_stateNext = S_ISSUE;
`endif
        end else if (w_tmoHit) begin
          w_stateNext = S_IDLE;
        end
      end
`ifdef DBG_FRAME_CSUM_EN
      S_CSUM: begin
        if (w_rxFire) begin
          w_stateNext = (rx_data_i == r_csum) ? S_ISSUE : S_ERR;
        end else if (w_tmoHit) begin
          w_stateNext = S_IDLE;
        end
      end
      S_ERR: begin
        tx_valid_o = 1'b1;
        tx_data_o  = 8'hEE;
        if (tx_ready_i) w_stateNext = S_IDLE;
      end
`endif
      S_ISSUE: begin
        dbg_cmd_o   = r_cmd;
        w_stateNext = S_WAIT;
      end
      S_WAIT: begin
        dbg_cmd_o = r_cmd;
        if (dbg_ready_i) w_stateNext = S_RESP;
      end
      S_RESP: begin
        tx_valid_o = 1'b1;
        tx_data_o  = r_resp[{r_idx, 3'b000} +: 8];
        if (w_txFire && (r_idx == 2'd3)) w_stateNext = S_IDLE;
      end
      default: w_stateNext = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst_i) begin
      r_state <= S_IDLE;
      r_idx   <= 2'd0;
      r_tmo   <= 32'd0;
      r_cmd   <= 8'h00;
      r_addr  <= 32'd0;
      r_data  <= 32'd0;
      r_resp  <= 32'd0;
`ifdef DBG_FRAME_CSUM_EN
      r_csum  <= 8'h00;
`endif
    end else begin
      r_state <= w_stateNext;

      // The counter only runs while a frame is partially received and no byte arrives.
      if (w_rxFire || !w_frameState) r_tmo <= 32'd0;
      else                           r_tmo <= r_tmo + 32'd1;

      case (r_state)
        S_IDLE: begin
          if (w_rxFire && (rx_data_i != 8'h00)) begin
            r_cmd  <= rx_data_i;
            r_idx  <= 2'd0;
`ifdef DBG_FRAME_CSUM_EN
            r_csum <= rx_data_i;
`endif
          end
        end
        S_ADDR: begin
          if (w_rxFire) begin
            r_addr[{r_idx, 3'b000} +: 8] <= rx_data_i;
            r_idx <= r_idx + 2'd1;
`ifdef DBG_FRAME_CSUM_EN
            r_csum <= r_csum ^ rx_data_i;
`endif
          end
        end
        S_DATA: begin
          if (w_rxFire) begin
            r_data[{r_idx, 3'b000} +: 8] <= rx_data_i;
            r_idx <= r_idx + 2'd1;
`ifdef DBG_FRAME_CSUM_EN
            r_csum <= r_csum ^ rx_data_i;
`endif
          end
        end
        S_WAIT: begin
          if (dbg_ready_i) begin
            r_resp <= dbg_data_i;
            r_idx  <= 2'd0;
          end
        end
        S_RESP: begin
          if (w_txFire) r_idx <= r_idx + 2'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_dbg_frame_bridge.sv
// Scoreboard bench for dbg_frame_bridge: expected debug commands and tx bytes are queued when driven and checked as they appear.
// Build with DBG_FRAME_CSUM_EN defined to exercise the checksum variant.
module tb_dbg_frame_bridge;

  logic        clk = 1'b0;
  logic        rst_i = 1'b1;
  logic [7:0]  rx_data_i = 8'h00;
  logic        rx_valid_i = 1'b0;
  logic        rx_ready_o;
  logic [7:0]  tx_data_o;
  logic        tx_valid_o;
  logic        tx_ready_i = 1'b0;
  logic [7:0]  dbg_cmd_o;
  logic [31:0] dbg_addr_o;
  logic [31:0] dbg_data_o;
  logic [31:0] dbg_data_i = 32'd0;
  logic        dbg_ready_i = 1'b0;
  logic        busy_o;

  int compared = 0;
  int mismatched = 0;

  logic [7:0]  expCmdQ[$];
  logic [31:0] expAddrQ[$];
  logic [31:0] expDataQ[$];
  logic [7:0]  expTxQ[$];

  dbg_frame_bridge #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .rst_i(rst_i),
    .rx_data_i(rx_data_i), .rx_valid_i(rx_valid_i), .rx_ready_o(rx_ready_o),
    .tx_data_o(tx_data_o), .tx_valid_o(tx_valid_o), .tx_ready_i(tx_ready_i),
    .dbg_cmd_o(dbg_cmd_o), .dbg_addr_o(dbg_addr_o), .dbg_data_o(dbg_data_o),
    .dbg_data_i(dbg_data_i), .dbg_ready_i(dbg_ready_i), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Debug-side monitor: pops an expected command on each new issue and checks operands stay put.
  logic [7:0]  prevCmd = 8'h00;
  logic [31:0] prevAddr = 32'd0;
  logic [31:0] prevData = 32'd0;
  always @(negedge clk) begin
    if (dbg_cmd_o !== 8'h00 && prevCmd === 8'h00) begin
      if (expCmdQ.size() == 0) begin
        checkOutput("unexpected_cmd", {24'd0, dbg_cmd_o}, 32'd0);
      end else begin
        checkOutput("issue_cmd", {24'd0, dbg_cmd_o}, {24'd0, expCmdQ.pop_front()});
        checkOutput("issue_addr", dbg_addr_o, expAddrQ.pop_front());
        checkOutput("issue_data", dbg_data_o, expDataQ.pop_front());
      end
    end else if (dbg_cmd_o !== 8'h00) begin
      checkOutput("hold_cmd", {24'd0, dbg_cmd_o}, {24'd0, prevCmd});
      checkOutput("hold_addr", dbg_addr_o, prevAddr);
      checkOutput("hold_data", dbg_data_o, prevData);
    end
    prevCmd  <= dbg_cmd_o;
    prevAddr <= dbg_addr_o;
    prevData <= dbg_data_o;
  end

  // Host-side monitor: every tx transfer must match the next queued byte; stalled bytes must not move.
  logic       prevTxValid = 1'b0;
  logic       prevTxReady = 1'b0;
  logic [7:0] prevTxData = 8'h00;
  always @(negedge clk) begin
    if (prevTxValid && !prevTxReady && !rst_i) begin
      checkOutput("tx_hold_valid", {31'd0, tx_valid_o}, 32'd1);
      checkOutput("tx_hold_data", {24'd0, tx_data_o}, {24'd0, prevTxData});
    end
    if (tx_valid_o && tx_ready_i) begin
      if (expTxQ.size() == 0) checkOutput("unexpected_tx", {24'd0, tx_data_o}, 32'hFFFF_FFFF);
      else                    checkOutput("tx_byte", {24'd0, tx_data_o}, {24'd0, expTxQ.pop_front()});
    end
    prevTxValid <= tx_valid_o;
    prevTxReady <= tx_ready_i;
    prevTxData  <= tx_data_o;
  end

  task automatic applyStimulus(input logic [7:0] b);
    int n = 0;
    rx_data_i  = b;
    rx_valid_i = 1'b1;
    @(negedge clk);
    while (!rx_ready_o && n < 100) begin
      n++;
      @(negedge clk);
    end
    if (!rx_ready_o) checkOutput("rx_accept_timeout", {31'd0, rx_ready_o}, 32'd1);
    @(posedge clk);
    #1;
    rx_valid_i = 1'b0;
  endtask

  // Sends one frame; stallAt/stallCycles inserts an rx gap after byte index stallAt.
  task automatic sendFrame(input logic [7:0] cmd, input logic [31:0] addr, input logic [31:0] data,
                           input bit expectIssue, input bit badCsum, input int stallAt, input int stallCycles);
    logic [7:0] bytes[9];
    logic [7:0] csum;
    bytes[0] = cmd;
    for (int i = 0; i < 4; i++) begin
      bytes[1 + i] = addr[8*i +: 8];
      bytes[5 + i] = data[8*i +: 8];
    end
    csum = 8'h00;
    for (int i = 0; i < 9; i++) csum = csum ^ bytes[i];
    if (expectIssue) begin
      expCmdQ.push_back(cmd);
      expAddrQ.push_back(addr);
      expDataQ.push_back(data);
    end
    for (int i = 0; i < 9; i++) begin
      applyStimulus(bytes[i]);
      if (i == stallAt) repeat (stallCycles) begin
        @(posedge clk);
        #1;
      end
    end
`ifdef DBG_FRAME_CSUM_EN
    applyStimulus(badCsum ? ~csum : csum);
`else
    if (badCsum) $display("[TB] checksum variant not built; frame sent without checksum");
`endif
    if (expectIssue) checkOutput("issue_next_cycle", {24'd0, dbg_cmd_o}, {24'd0, cmd});
  endtask

  task automatic doRead(input logic [31:0] rdata, input int holdCycles, input bit toggle);
    int n = 0;
    repeat (holdCycles) begin
      @(posedge clk);
      #1;
      checkOutput("wait_busy", {31'd0, busy_o}, 32'd1);
    end
    dbg_data_i  = rdata;
    dbg_ready_i = 1'b1;
    for (int i = 0; i < 4; i++) expTxQ.push_back(rdata[8*i +: 8]);
    @(posedge clk);
    #1;
    dbg_ready_i = 1'b0;
    dbg_data_i  = 32'd0;
    checkOutput("cmd_cleared", {24'd0, dbg_cmd_o}, 32'd0);
    checkOutput("resp_valid", {31'd0, tx_valid_o}, 32'd1);
    tx_ready_i = 1'b1;
    while (busy_o && n < 50) begin
      @(posedge clk);
      #1;
      n++;
      if (toggle) tx_ready_i = ~tx_ready_i;
    end
    tx_ready_i = 1'b0;
    checkOutput("resp_done", {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    // Reset state
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_rx_ready", {31'd0, rx_ready_o}, 32'd0);
    checkOutput("rst_busy", {31'd0, busy_o}, 32'd0);
    checkOutput("rst_cmd", {24'd0, dbg_cmd_o}, 32'd0);
    checkOutput("rst_addr", dbg_addr_o, 32'd0);
    checkOutput("rst_data", dbg_data_o, 32'd0);
    checkOutput("rst_tx_valid", {31'd0, tx_valid_o}, 32'd0);
    checkOutput("rst_tx_data", {24'd0, tx_data_o}, 32'd0);
    rst_i = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("idle_rx_ready", {31'd0, rx_ready_o}, 32'd1);

    // Write frame, operands held through a long WAIT
    sendFrame(8'h01, 32'h0000_4000, 32'hDEAD_BEEF, 1'b1, 1'b0, -1, 0);
    doRead(32'hCAFE_F00D, 6, 1'b0);

    // Read with a stalling host link
    sendFrame(8'h02, 32'h0000_0100, 32'h0000_0000, 1'b1, 1'b0, -1, 0);
    doRead(32'h1234_5678, 2, 1'b1);

    // A NOP byte in IDLE is dropped
    applyStimulus(8'h00);
    checkOutput("nop_idle", {31'd0, busy_o}, 32'd0);
    sendFrame(8'h03, 32'hA5A5_0001, 32'h0F0F_F0F0, 1'b1, 1'b0, -1, 0);
    doRead(32'h0000_00FF, 1, 1'b0);

    // Partial frame times out after 16 silent cycles
    applyStimulus(8'h04);
    applyStimulus(8'h11);
    applyStimulus(8'h22);
    applyStimulus(8'h33);
    repeat (15) begin
      @(posedge clk);
      #1;
    end
    checkOutput("tmo_before", {31'd0, busy_o}, 32'd1);
    @(posedge clk);
    #1;
    checkOutput("tmo_dropped", {31'd0, busy_o}, 32'd0);
    sendFrame(8'h05, 32'h1000_0000, 32'h2000_0000, 1'b1, 1'b0, -1, 0);
    doRead(32'h8765_4321, 1, 1'b0);

    // A byte arriving on the last counting cycle wins over the timeout
    sendFrame(8'h06, 32'h0102_0304, 32'h0506_0708, 1'b1, 1'b0, 3, 15);
    doRead(32'h5555_AAAA, 1, 1'b0);

    // Reset during WAIT abandons the transaction
    sendFrame(8'h07, 32'h0000_0044, 32'h0000_0099, 1'b1, 1'b0, -1, 0);
    repeat (2) @(posedge clk);
    #1;
    rst_i = 1'b1;
    @(posedge clk);
    #1;
    rst_i = 1'b0;
    checkOutput("wait_rst_cmd", {24'd0, dbg_cmd_o}, 32'd0);
    checkOutput("wait_rst_busy", {31'd0, busy_o}, 32'd0);
    dbg_ready_i = 1'b1;
    tx_ready_i  = 1'b1;
    @(posedge clk);
    #1;
    dbg_ready_i = 1'b0;
    checkOutput("late_ready_tx", {31'd0, tx_valid_o}, 32'd0);
    checkOutput("late_ready_busy", {31'd0, busy_o}, 32'd0);
    tx_ready_i = 1'b0;
    sendFrame(8'h08, 32'h0000_0200, 32'h1111_2222, 1'b1, 1'b0, -1, 0);
    doRead(32'h3333_4444, 1, 1'b1);

`ifdef DBG_FRAME_CSUM_EN
    // Corrupted checksum is answered with 0xEE only
    sendFrame(8'h09, 32'h0000_0300, 32'h7777_8888, 1'b0, 1'b1, -1, 0);
    checkOutput("csum_err_valid", {31'd0, tx_valid_o}, 32'd1);
    expTxQ.push_back(8'hEE);
    tx_ready_i = 1'b1;
    @(posedge clk);
    #1;
    tx_ready_i = 1'b0;
    checkOutput("csum_err_done", {31'd0, busy_o}, 32'd0);
    sendFrame(8'h0A, 32'h0000_0304, 32'h9999_0000, 1'b1, 1'b0, -1, 0);
    doRead(32'hABCD_EF01, 1, 1'b0);
`endif

    repeat (4) @(posedge clk);
    #1;
    checkOutput("cmdq_drained", expCmdQ.size(), 32'd0);
    checkOutput("txq_drained", expTxQ.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
